// File: rtl/qspi_pkg.sv
// Shared register map, CSN bit position and read-sequencer state encoding.
package qspi_pkg;

  localparam logic [3:0] REG_CFG0 = 4'd0;
  localparam logic [3:0] REG_CFG1 = 4'd1;
  localparam logic [3:0] REG_DATA = 4'd2;

  localparam int unsigned CSN_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_DIV,
    ST_CFG_MODE,
    ST_CS_LOW,
    ST_CMD,
    ST_ADR2,
    ST_ADR1,
    ST_ADR0,
    ST_RD,
    ST_CS_HIGH
  } state_t;

  // config1 value: divider in [7:4], CSN (active-low) at CSN_BIT, rest zero
  function automatic logic [7:0] cfg1_val(input logic [3:0] div, input logic csn);
    logic [7:0] v;
    v = {div, 4'b0000};
    v[CSN_BIT] = csn;
    return v;
  endfunction

endpackage

// File: rtl/qspi_flash_rd.sv
// Flash read sequencer: drives a QSPI wrapper over a simple register bus
// (configure, assert CSN, send opcode + 24-bit address, stream bytes back).
module qspi_flash_rd
  import qspi_pkg::*;
#(
  parameter logic [3:0] DIV      = 4'd2,
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] CFG0_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req_vld,
  output logic        rd_req_rdy,
  input  logic [23:0] rd_req_addr,
  input  logic [7:0]  rd_req_len,
  output logic        rd_dat_vld,
  input  logic        rd_dat_rdy,
  output logic [7:0]  rd_dat,
  output logic        rd_dat_last,
  output logic        busy,
  output logic        qspi_if_req_vld,
  input  logic        qspi_if_req_rdy,
  output logic [3:0]  qspi_if_req_addr,
  output logic        qspi_if_req_read,
  output logic [7:0]  qspi_if_req_dat,
  input  logic        qspi_if_rsp_vld,
  output logic        qspi_if_rsp_rdy,
  input  logic [7:0]  qspi_if_rsp_dat
);

  state_t      state_q, state_d;
  logic        out_q;
  logic [8:0]  cnt_q;
  logic [23:0] addr_q;

  logic req_hs, rsp_hs, active, in_rd, accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Outstanding flag, captured address and remaining-byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      if (rsp_hs)      out_q <= 1'b0;
      else if (req_hs) out_q <= 1'b1;
      if (accept) begin
        addr_q <= rd_req_addr;
        cnt_q  <= (rd_req_len == 8'd0) ? 9'd256 : {1'b0, rd_req_len};
      end else if (in_rd && rsp_hs) begin
        cnt_q <= cnt_q - 9'd1;
      end
    end
  end

  // Bus request fields per step; a step's response may arrive in the same
  // cycle as its request, so "active" covers the request handshake too.
  always_comb begin
    qspi_if_req_addr = '0;
    qspi_if_req_read = 1'b0;
    qspi_if_req_dat  = '0;
    unique case (state_q)
      ST_CFG_DIV:  begin qspi_if_req_addr = REG_CFG1; qspi_if_req_dat = cfg1_val(DIV, 1'b1); end
      ST_CFG_MODE: begin qspi_if_req_addr = REG_CFG0; qspi_if_req_dat = CFG0_VAL; end
      ST_CS_LOW:   begin qspi_if_req_addr = REG_CFG1; qspi_if_req_dat = cfg1_val(DIV, 1'b0); end
      ST_CMD:      begin qspi_if_req_addr = REG_DATA; qspi_if_req_dat = CMD_READ; end
      ST_ADR2:     begin qspi_if_req_addr = REG_DATA; qspi_if_req_dat = addr_q[23:16]; end
      ST_ADR1:     begin qspi_if_req_addr = REG_DATA; qspi_if_req_dat = addr_q[15:8]; end
      ST_ADR0:     begin qspi_if_req_addr = REG_DATA; qspi_if_req_dat = addr_q[7:0]; end
      ST_RD:       begin qspi_if_req_addr = REG_DATA; qspi_if_req_read = 1'b1; end
      ST_CS_HIGH:  begin qspi_if_req_addr = REG_CFG1; qspi_if_req_dat = cfg1_val(DIV, 1'b1); end
      default:     ;
    endcase

    rd_req_rdy      = (state_q == ST_IDLE);
    busy            = (state_q != ST_IDLE);
    accept          = rd_req_rdy && rd_req_vld;
    in_rd           = (state_q == ST_RD);
    qspi_if_req_vld = busy && !out_q;
    req_hs          = qspi_if_req_vld && qspi_if_req_rdy;
    active          = out_q || req_hs;
    qspi_if_rsp_rdy = (in_rd && active) ? rd_dat_rdy : 1'b1;
    rsp_hs          = qspi_if_rsp_vld && qspi_if_rsp_rdy && active;
    rd_dat_vld      = in_rd && active && qspi_if_rsp_vld;
    rd_dat          = qspi_if_rsp_dat;
    rd_dat_last     = in_rd && (cnt_q == 9'd1);
  end

  // Next-state: each step advances on its response handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = ST_CFG_DIV;
      ST_CFG_DIV:  if (rsp_hs) state_d = ST_CFG_MODE;
      ST_CFG_MODE: if (rsp_hs) state_d = ST_CS_LOW;
      ST_CS_LOW:   if (rsp_hs) state_d = ST_CMD;
      ST_CMD:      if (rsp_hs) state_d = ST_ADR2;
      ST_ADR2:     if (rsp_hs) state_d = ST_ADR1;
      ST_ADR1:     if (rsp_hs) state_d = ST_ADR0;
      ST_ADR0:     if (rsp_hs) state_d = ST_RD;
      ST_RD:       if (rsp_hs && cnt_q == 9'd1) state_d = ST_CS_HIGH;
      ST_CS_HIGH:  if (rsp_hs) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

endmodule
